hazard_stall_ctrl: RTL and testbench
====================================

HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 SHALL have parameter MULT_LAT, default 3, meaning EX-stage occupancy in cycles of a MUL instruction; legal range 1..15.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the statistics counters.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port arst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have ports id_rs1 and id_rs2, input, 5 each: source registers of the instruction in ID.
REQ-006 SHALL have port ex_rd, input, 5: destination register of the instruction in EX.
REQ-007 SHALL have port ex_mem_read, input, 1: the EX instruction is a load.
REQ-008 SHALL have port ex_is_mul, input, 1: the EX instruction is a MUL.
REQ-009 SHALL have port ex_branch_taken, input, 1: EX resolved a taken branch or jump.
REQ-010 SHALL have outputs pc_write, if_id_write and id_ex_write, 1 each: register enables; 1 = advance.
REQ-011 SHALL have outputs id_ex_bubble and ex_mem_bubble, 1 each: load zero control into that pipeline register.
REQ-012 SHALL have outputs flush_if_id and flush_id_ex, 1 each: squash the contents of that pipeline register.
REQ-013 SHALL have outputs mult_en (1) and mult_done (1): multiplier enable, and final-cycle pulse.
REQ-014 SHALL have outputs stall_cnt and flush_cnt, CNT_W each: saturating event counters.

Function
REQ-015 SHALL implement FSM states IDLE and MUL_BUSY, plus a 4-bit down-counter mcnt.
REQ-016 SHALL define mul_stall = (IDLE & ex_is_mul & MULT_LAT>1) | (MUL_BUSY & mcnt!=0).
REQ-017 SHALL, in IDLE with ex_is_mul=1 and MULT_LAT>1, go to MUL_BUSY with mcnt=MULT_LAT-2.
REQ-018 SHALL, in MUL_BUSY, decrement mcnt; when mcnt==0, return to IDLE.
REQ-019 SHALL drive mult_en=1 whenever (IDLE & ex_is_mul) or MUL_BUSY.
REQ-020 SHALL pulse mult_done in the last EX cycle of a MUL: MUL_BUSY & mcnt==0, or IDLE & ex_is_mul when MULT_LAT==1.
REQ-021 SHALL, when mul_stall=1, drive pc_write=0, if_id_write=0, id_ex_write=0, ex_mem_bubble=1, with all flush outputs 0.
REQ-022 SHALL define load_use = ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
REQ-023 SHALL, when not mul_stall and ex_branch_taken=1, drive flush_if_id=1 and flush_id_ex=1 with all enables 1 and load_use ignored.
REQ-024 SHALL, when not mul_stall, not ex_branch_taken and load_use=1, drive pc_write=0, if_id_write=0 and id_ex_bubble=1 for exactly that cycle.
REQ-025 SHALL apply priority mul_stall > branch flush > load_use.
REQ-026 SHALL, with no hazard present, drive all enables to 1 and all bubble and flush outputs to 0.
REQ-027 SHALL make all stall, flush and bubble outputs combinational from the current state and inputs (zero latency).
REQ-028 SHALL start a new MUL sequence in the cycle immediately after mult_done, if ex_is_mul=1 again (back-to-back MULs).
REQ-029 SHALL increment stall_cnt in each cycle where pc_write=0, and flush_cnt in each cycle where flush_if_id=1; both saturate at all-ones.

Reset
REQ-030 SHALL, on arst, immediately set state=IDLE, mcnt=0, stall_cnt=0 and flush_cnt=0.
REQ-031 SHALL, while reset is held and all inputs are 0, drive enables=1, bubbles=0, flushes=0, mult_en=0 and mult_done=0.
REQ-032 SHALL, on a reset asserted mid-MUL, abort the sequence, emit no mult_done, and resume in IDLE.

Structure
REQ-033 SHALL place the FSM state typedef and the MULT_LAT legal-range constants in a shared package, hazard_pkg.
REQ-034 SHALL implement the FSM and mcnt as one sub-module, mult_seq_fsm, outputting mul_stall, mult_en and mult_done; hazard priority and counters stay in the top level.

Verification
REQ-035 SHALL cover a MUL with MULT_LAT=3, ex_is_mul=1 for 3 cycles -> pc_write=0 for cycles 1-2, mult_done=1 in cycle 3 only, and stall_cnt=2.
REQ-036 SHALL cover a load with ex_rd=5 and id_rs2=5 -> pc_write=0 and id_ex_bubble=1 for exactly 1 cycle; with ex_rd=0 -> no stall.
REQ-037 SHALL cover ex_branch_taken=1 together with load_use=1 -> flush_if_id=flush_id_ex=1, pc_write=1, flush_cnt=1.
REQ-038 SHALL cover two back-to-back MULs with MULT_LAT=3 -> 2 mult_done pulses 3 cycles apart and stall_cnt=4.
REQ-039 SHALL cover arst asserted in the 2nd MUL cycle -> state IDLE, mcnt=0, counters 0, and no mult_done.
REQ-040 SHALL cover MULT_LAT=1 with ex_is_mul=1 -> mult_done=1 and no stall; also stall_cnt forced to saturation -> remains at 16'hFFFF.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and limits for the hazard/stall controller and its MUL sequencer.
package hazard_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } mseq_state_e;

  localparam int unsigned MULT_LAT_MIN = 1;
  localparam int unsigned MULT_LAT_MAX = 15;
  localparam int unsigned MCNT_W       = 4;

  // Clamp a requested MUL latency into the range the 4-bit down-counter can cover.
  function automatic int unsigned clamp_lat(input int unsigned lat);
    if (lat < MULT_LAT_MIN) return MULT_LAT_MIN;
    if (lat > MULT_LAT_MAX) return MULT_LAT_MAX;
    return lat;
  endfunction

  // The first EX cycle is spent in IDLE and the last with mcnt==0, hence lat-2.
  function automatic logic [MCNT_W-1:0] mcnt_init(input int unsigned lat);
    if (lat > 1) return MCNT_W'(lat - 2);
    return '0;
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle; master is the pipeline, slave is the controller.
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 16
);

  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic [4:0]       ex_rd;
  logic             ex_mem_read;
  logic             ex_is_mul;
  logic             ex_branch_taken;

  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_write;
  logic             id_ex_bubble;
  logic             ex_mem_bubble;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             mult_en;
  logic             mult_done;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, ex_rd, ex_mem_read, ex_is_mul, ex_branch_taken,
    input  pc_write, if_id_write, id_ex_write, id_ex_bubble, ex_mem_bubble,
    input  flush_if_id, flush_id_ex, mult_en, mult_done, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, ex_rd, ex_mem_read, ex_is_mul, ex_branch_taken,
    output pc_write, if_id_write, id_ex_write, id_ex_bubble, ex_mem_bubble,
    output flush_if_id, flush_id_ex, mult_en, mult_done, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_stall_ctrl_mult_seq_fsm.sv
// Multi-cycle MUL sequencer: holds the pipeline while a MUL occupies EX for MULT_LAT cycles.
module mult_seq_fsm
  import hazard_pkg::*;
#(
  parameter int unsigned MULT_LAT = 3
) (
  input  logic clk,
  input  logic arst,
  input  logic ex_is_mul,
  output logic mul_stall,
  output logic mult_en,
  output logic mult_done
);

  localparam int unsigned        LAT       = clamp_lat(MULT_LAT);
  localparam logic               MULTI     = (LAT > 1);
  localparam logic [MCNT_W-1:0]  MCNT_INIT = mcnt_init(LAT);

  mseq_state_e       state_q;
  logic [MCNT_W-1:0] mcnt_q;
  logic              in_idle;
  logic              in_busy;
  logic              mcnt_zero;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= IDLE;
      mcnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ex_is_mul && MULTI) begin
            state_q <= MUL_BUSY;
            mcnt_q  <= MCNT_INIT;
          end
        end
        MUL_BUSY: begin
          if (mcnt_q == '0) begin
            state_q <= IDLE;
          end else begin
            mcnt_q <= mcnt_q - MCNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          mcnt_q  <= '0;
        end
      endcase
    end
  end

  // Outputs must react in the same cycle the MUL arrives, so they decode state and input directly.
  always_comb begin
    in_idle   = (state_q == IDLE);
    in_busy   = (state_q == MUL_BUSY);
    mcnt_zero = (mcnt_q == '0);
    mul_stall = (in_idle && ex_is_mul && MULTI) || (in_busy && !mcnt_zero);
    mult_en   = (in_idle && ex_is_mul) || in_busy;
    mult_done = (in_busy && mcnt_zero) || (in_idle && ex_is_mul && !MULTI);
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: MUL occupancy stall > taken-branch flush > load-use bubble,
// with saturating stall/flush event counters.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MULT_LAT = 3,
  parameter int          CNT_W    = 16
) (
  input  logic                clk,
  input  logic                arst,
  hazard_stall_ctrl_if.slave  hz
);

  logic             mul_stall;
  logic             mult_en;
  logic             mult_done;
  logic             load_use;

  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_write;
  logic             id_ex_bubble;
  logic             ex_mem_bubble;
  logic             flush_if_id;
  logic             flush_id_ex;

  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d;

  mult_seq_fsm #(
    .MULT_LAT (MULT_LAT)
  ) u_mult_seq (
    .clk       (clk),
    .arst      (arst),
    .ex_is_mul (hz.ex_is_mul),
    .mul_stall (mul_stall),
    .mult_en   (mult_en),
    .mult_done (mult_done)
  );

  // x0 is hard-wired zero, so a load targeting it never creates a dependency.
  always_comb begin
    load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
               ((hz.ex_rd == hz.id_rs1) || (hz.ex_rd == hz.id_rs2));
  end

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    flush_if_id   = 1'b0;
    flush_id_ex   = 1'b0;
    if (mul_stall) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_bubble = 1'b1;
    end else if (hz.ex_branch_taken) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (load_use) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_write && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush_if_id && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.pc_write      = pc_write;
  assign hz.if_id_write   = if_id_write;
  assign hz.id_ex_write   = id_ex_write;
  assign hz.id_ex_bubble  = id_ex_bubble;
  assign hz.ex_mem_bubble = ex_mem_bubble;
  assign hz.flush_if_id   = flush_if_id;
  assign hz.flush_id_ex   = flush_id_ex;
  assign hz.mult_en       = mult_en;
  assign hz.mult_done     = mult_done;
  assign hz.stall_cnt     = stall_cnt_q;
  assign hz.flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: a MULT_LAT=3 instance and a MULT_LAT=1, 4-bit-counter instance.
module tb_hazard_stall_ctrl;

  logic clk  = 1'b0;
  logic arst = 1'b0;
  always #5 clk = ~clk;

  hazard_stall_ctrl_if #(.CNT_W(16)) hz3 ();
  hazard_stall_ctrl_if #(.CNT_W(4))  hz1 ();

  hazard_stall_ctrl #(.MULT_LAT(3), .CNT_W(16)) dut3 (.clk(clk), .arst(arst), .hz(hz3));
  hazard_stall_ctrl #(.MULT_LAT(1), .CNT_W(4))  dut1 (.clk(clk), .arst(arst), .hz(hz1));

  // {pc_write, if_id_write, id_ex_write, id_ex_bubble, ex_mem_bubble, flush_if_id, flush_id_ex, mult_en, mult_done}
  wire [8:0] out3 = {hz3.pc_write, hz3.if_id_write, hz3.id_ex_write, hz3.id_ex_bubble, hz3.ex_mem_bubble,
                     hz3.flush_if_id, hz3.flush_id_ex, hz3.mult_en, hz3.mult_done};
  wire [8:0] out1 = {hz1.pc_write, hz1.if_id_write, hz1.id_ex_write, hz1.id_ex_bubble, hz1.ex_mem_bubble,
                     hz1.flush_if_id, hz1.flush_id_ex, hz1.mult_en, hz1.mult_done};

  localparam logic [8:0] V_NORM     = 9'b111_00_00_00;
  localparam logic [8:0] V_MSTALL   = 9'b000_01_00_10;
  localparam logic [8:0] V_MDONE    = 9'b111_00_00_11;
  localparam logic [8:0] V_LOADUSE  = 9'b001_10_00_00;
  localparam logic [8:0] V_BRANCH   = 9'b111_00_11_00;
  localparam logic [8:0] V_BR_MDONE = 9'b111_00_11_11;

  int ncmp  = 0;
  int nfail = 0;
  logic [8:0] exp_q[$];

  task automatic zero_inputs();
    hz3.id_rs1 = '0; hz3.id_rs2 = '0; hz3.ex_rd = '0;
    hz3.ex_mem_read = 1'b0; hz3.ex_is_mul = 1'b0; hz3.ex_branch_taken = 1'b0;
    hz1.id_rs1 = '0; hz1.id_rs2 = '0; hz1.ex_rd = '0;
    hz1.ex_mem_read = 1'b0; hz1.ex_is_mul = 1'b0; hz1.ex_branch_taken = 1'b0;
  endtask

  // Drive one cycle of inputs just after the edge, return mid-cycle for sampling.
  task automatic apply3(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic mr, input logic mul, input logic br);
    @(posedge clk); #1;
    hz3.id_rs1 = rs1; hz3.id_rs2 = rs2; hz3.ex_rd = rd;
    hz3.ex_mem_read = mr; hz3.ex_is_mul = mul; hz3.ex_branch_taken = br;
    #5;
  endtask

  task automatic apply1(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic mr, input logic mul, input logic br);
    @(posedge clk); #1;
    hz1.id_rs1 = rs1; hz1.id_rs2 = rs2; hz1.ex_rd = rd;
    hz1.ex_mem_read = mr; hz1.ex_is_mul = mul; hz1.ex_branch_taken = br;
    #5;
  endtask

  task automatic idle_edge();
    @(posedge clk); #1;
    zero_inputs();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    zero_inputs();
    arst = 1'b1;
    @(posedge clk); #1;
    arst = 1'b0;
  endtask

  task automatic test_reset();
    logic [8:0] e;
    @(posedge clk); #1;
    zero_inputs();
    arst = 1'b1;
    exp_q.push_back(V_NORM);
    exp_q.push_back(V_NORM);
    #2;
    e = exp_q.pop_front(); ncmp++;
    if (out3 !== e) begin $display("FAIL reset_out3 got %b exp %b", out3, e); nfail++; end
    e = exp_q.pop_front(); ncmp++;
    if (out1 !== e) begin $display("FAIL reset_out1 got %b exp %b", out1, e); nfail++; end
    ncmp++;
    if (hz3.stall_cnt !== 16'd0 || hz3.flush_cnt !== 16'd0) begin
      $display("FAIL reset_cnt got stall=%0d flush=%0d exp 0/0", hz3.stall_cnt, hz3.flush_cnt); nfail++;
    end
    @(posedge clk); #1;
    arst = 1'b0;
  endtask

  task automatic test_mul_single();
    logic [8:0] e;
    do_reset();
    exp_q.push_back(V_MSTALL); exp_q.push_back(V_MSTALL); exp_q.push_back(V_MDONE);
    for (int i = 0; i < 3; i++) begin
      apply3(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      e = exp_q.pop_front(); ncmp++;
      if (out3 !== e) begin $display("FAIL mul_single_c%0d got %b exp %b", i, out3, e); nfail++; end
    end
    idle_edge();
    ncmp++;
    if (hz3.stall_cnt !== 16'd2) begin $display("FAIL mul_single_stall_cnt got %0d exp 2", hz3.stall_cnt); nfail++; end
    #5;
    exp_q.push_back(V_NORM);
    e = exp_q.pop_front(); ncmp++;
    if (out3 !== e) begin $display("FAIL mul_single_after got %b exp %b", out3, e); nfail++; end
  endtask

  task automatic test_load_use();
    logic [8:0] e;
    do_reset();
    exp_q.push_back(V_LOADUSE);
    apply3(5'd3, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0);
    e = exp_q.pop_front(); ncmp++;
    if (out3 !== e) begin $display("FAIL load_use_rs2 got %b exp %b", out3, e); nfail++; end
    exp_q.push_back(V_NORM);
    apply3(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    e = exp_q.pop_front(); ncmp++;
    if (out3 !== e) begin $display("FAIL load_use_x0 got %b exp %b", out3, e); nfail++; end
    exp_q.push_back(V_NORM);
    apply3(5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 1'b0);
    e = exp_q.pop_front(); ncmp++;
    if (out3 !== e) begin $display("FAIL load_nodep got %b exp %b", out3, e); nfail++; end
    exp_q.push_back(V_NORM);
    apply3(5'd9, 5'd0, 5'd9, 1'b0, 1'b0, 1'b0);
    e = exp_q.pop_front(); ncmp++;
    if (out3 !== e) begin $display("FAIL nonload_dep got %b exp %b", out3, e); nfail++; end
    exp_q.push_back(V_LOADUSE);
    apply3(5'd9, 5'd1, 5'd9, 1'b1, 1'b0, 1'b0);
    e = exp_q.pop_front(); ncmp++;
    if (out3 !== e) begin $display("FAIL load_use_rs1 got %b exp %b", out3, e); nfail++; end
    idle_edge();
    ncmp++;
    if (hz3.stall_cnt !== 16'd2) begin $display("FAIL load_use_stall_cnt got %0d exp 2", hz3.stall_cnt); nfail++; end
  endtask

  task automatic test_branch();
    logic [8:0] e;
    do_reset();
    exp_q.push_back(V_BRANCH);
    apply3(5'd0, 5'd5, 5'd5, 1'b1, 1'b0, 1'b1);
    e = exp_q.pop_front(); ncmp++;
    if (out3 !== e) begin $display("FAIL branch_over_load got %b exp %b", out3, e); nfail++; end
    idle_edge();
    ncmp++;
    if (hz3.flush_cnt !== 16'd1 || hz3.stall_cnt !== 16'd0) begin
      $display("FAIL branch_cnt got flush=%0d stall=%0d exp 1/0", hz3.flush_cnt, hz3.stall_cnt); nfail++;
    end
    exp_q.push_back(V_MSTALL); exp_q.push_back(V_MSTALL); exp_q.push_back(V_BR_MDONE);
    for (int i = 0; i < 3; i++) begin
      apply3(5'd0, 5'd0, 5'd0, 1'b0, (i == 0), 1'b1);
      e = exp_q.pop_front(); ncmp++;
      if (out3 !== e) begin $display("FAIL branch_vs_mul_c%0d got %b exp %b", i, out3, e); nfail++; end
    end
    idle_edge();
    ncmp++;
    if (hz3.flush_cnt !== 16'd2 || hz3.stall_cnt !== 16'd2) begin
      $display("FAIL branch_mul_cnt got flush=%0d stall=%0d exp 2/2", hz3.flush_cnt, hz3.stall_cnt); nfail++;
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] e;
    int ndone;
    int first_done;
    int gap;
    ndone = 0; first_done = -1; gap = -1;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(V_MSTALL); exp_q.push_back(V_MSTALL); exp_q.push_back(V_MDONE);
    end
    for (int i = 0; i < 6; i++) begin
      apply3(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      if (hz3.mult_done === 1'b1) begin
        if (first_done < 0) first_done = i;
        else gap = i - first_done;
        ndone++;
      end
      e = exp_q.pop_front(); ncmp++;
      if (out3 !== e) begin $display("FAIL b2b_c%0d got %b exp %b", i, out3, e); nfail++; end
    end
    idle_edge();
    ncmp++;
    if (ndone != 2 || gap != 3) begin $display("FAIL b2b_done got n=%0d gap=%0d exp 2/3", ndone, gap); nfail++; end
    ncmp++;
    if (hz3.stall_cnt !== 16'd4) begin $display("FAIL b2b_stall_cnt got %0d exp 4", hz3.stall_cnt); nfail++; end
  endtask

  task automatic test_reset_mid_mul();
    logic [8:0] e;
    do_reset();
    exp_q.push_back(V_MSTALL); exp_q.push_back(V_MSTALL);
    for (int i = 0; i < 2; i++) begin
      apply3(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      e = exp_q.pop_front(); ncmp++;
      if (out3 !== e) begin $display("FAIL rst_mul_c%0d got %b exp %b", i, out3, e); nfail++; end
    end
    #2;
    arst = 1'b1;
    hz3.ex_is_mul = 1'b0;
    #1;
    exp_q.push_back(V_NORM);
    e = exp_q.pop_front(); ncmp++;
    if (out3 !== e) begin $display("FAIL rst_mul_abort got %b exp %b", out3, e); nfail++; end
    ncmp++;
    if (hz3.stall_cnt !== 16'd0 || hz3.flush_cnt !== 16'd0) begin
      $display("FAIL rst_mul_cnt got stall=%0d flush=%0d exp 0/0", hz3.stall_cnt, hz3.flush_cnt); nfail++;
    end
    @(posedge clk); #1;
    arst = 1'b0;
    exp_q.push_back(V_NORM);
    apply3(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    e = exp_q.pop_front(); ncmp++;
    if (out3 !== e) begin $display("FAIL rst_mul_resume_idle got %b exp %b", out3, e); nfail++; end
    exp_q.push_back(V_MSTALL); exp_q.push_back(V_MSTALL); exp_q.push_back(V_MDONE);
    for (int i = 0; i < 3; i++) begin
      apply3(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      e = exp_q.pop_front(); ncmp++;
      if (out3 !== e) begin $display("FAIL rst_mul_fresh_c%0d got %b exp %b", i, out3, e); nfail++; end
    end
    idle_edge();
    ncmp++;
    if (hz3.stall_cnt !== 16'd2) begin $display("FAIL rst_mul_fresh_cnt got %0d exp 2", hz3.stall_cnt); nfail++; end
  endtask

  task automatic test_mult_lat1();
    logic [8:0] e;
    do_reset();
    exp_q.push_back(V_MDONE); exp_q.push_back(V_MDONE);
    for (int i = 0; i < 2; i++) begin
      apply1(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      e = exp_q.pop_front(); ncmp++;
      if (out1 !== e) begin $display("FAIL lat1_c%0d got %b exp %b", i, out1, e); nfail++; end
    end
    exp_q.push_back(V_NORM);
    apply1(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    e = exp_q.pop_front(); ncmp++;
    if (out1 !== e) begin $display("FAIL lat1_after got %b exp %b", out1, e); nfail++; end
    idle_edge();
    ncmp++;
    if (hz1.stall_cnt !== 4'd0) begin $display("FAIL lat1_stall_cnt got %0d exp 0", hz1.stall_cnt); nfail++; end
  endtask

  task automatic test_saturation();
    logic [8:0] e;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      apply1(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
    end
    exp_q.push_back(V_LOADUSE);
    e = exp_q.pop_front(); ncmp++;
    if (out1 !== e) begin $display("FAIL sat_load_use got %b exp %b", out1, e); nfail++; end
    idle_edge();
    ncmp++;
    if (hz1.stall_cnt !== 4'hF) begin $display("FAIL sat_stall_cnt got %h exp F", hz1.stall_cnt); nfail++; end
    for (int i = 0; i < 3; i++) begin
      apply1(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
    end
    for (int i = 0; i < 18; i++) begin
      apply1(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    end
    idle_edge();
    ncmp++;
    if (hz1.stall_cnt !== 4'hF) begin $display("FAIL sat_stall_hold got %h exp F", hz1.stall_cnt); nfail++; end
    ncmp++;
    if (hz1.flush_cnt !== 4'hF) begin $display("FAIL sat_flush_cnt got %h exp F", hz1.flush_cnt); nfail++; end
  endtask

  initial begin
    zero_inputs();
    test_reset();
    test_mul_single();
    test_load_use();
    test_branch();
    test_back_to_back();
    test_reset_mid_mul();
    test_mult_lat1();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
